// File: rtl/pavana_xbar_pkg.sv
// Shared definitions for the pavana OOO crossbar and its slave models:
// command encodings, default tag width, LFSR taps and counter sizing.
package pavana_xbar_pkg;

   localparam int unsigned TID_W_DEF = 2;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

   // Galois form of x^16 + x^14 + x^13 + x^11 for a right-shifting register.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Countdown width: clog2(LAT_MIN+LAT_MASK), but never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned lat_min,
                                             input int unsigned lat_mask);
      int unsigned w;
      w = $clog2(lat_min + lat_mask);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/pavana_lfsr16.sv
// 16-bit Galois LFSR used to randomise slave read latency.
module pavana_lfsr16
   import pavana_xbar_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [15:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= SEED;
      end else if (en) begin
         q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : '0);
      end
   end

endmodule

// File: rtl/pavana_ooo_slave_mem.sv
// Out-of-order memory slave: writes complete on accept, reads return tagged
// data after a pseudo-random latency from a small pool of pending slots.
module pavana_ooo_slave_mem
   import pavana_xbar_pkg::*;
#(
   parameter int unsigned AW_WORDS  = 10,
   parameter int unsigned TID_W     = TID_W_DEF,
   parameter int unsigned SLOTS     = 4,
   parameter int unsigned LAT_MIN   = 1,
   parameter int unsigned LAT_MASK  = 7,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic [31:0]      addr_i,
   input  logic             cmd_i,
   input  logic [TID_W-1:0] reqtid_i,
   input  logic [31:0]      wdata_i,
   output logic             ack_o,
   output logic             resp_o,
   output logic [TID_W-1:0] resptid_o,
   output logic [31:0]      rdata_o
);

   localparam int unsigned CW    = cnt_width(LAT_MIN, LAT_MASK);
   localparam int unsigned DEPTH = 1 << AW_WORDS;
   localparam int unsigned SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   typedef struct packed {
      logic             valid;
      logic [TID_W-1:0] tid;
      logic [CW-1:0]    cnt;
      logic [31:0]      data;
   } slot_t;

   slot_t               slots     [SLOTS];
   slot_t               slots_nxt [SLOTS];
   logic [31:0]         mem       [DEPTH];
   logic [15:0]         lfsr;
   logic [AW_WORDS-1:0] word;
   logic [SW-1:0]       free_idx;
   logic [SW-1:0]       elig_idx;
   logic                any_free;
   logic                any_elig;
   logic                rd_accept;
   logic                wr_accept;
   logic [2:0]          extra;
   logic [CW-1:0]       init_cnt;
   logic                unused_bits;

   pavana_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (1'b1),
      .q     (lfsr)
   );

   assign word        = addr_i[AW_WORDS+1:2];
   assign unused_bits = ^{addr_i[31:AW_WORDS+2], addr_i[1:0], lfsr[15:3]};

   // Both encoders look only at registered state, so a slot retiring this
   // cycle is still seen as busy by the free-slot search.
   always_comb begin
      free_idx = '0;
      elig_idx = '0;
      any_free = 1'b0;
      any_elig = 1'b0;
      for (int unsigned i = SLOTS; i > 0; i--) begin
         if (!slots[i-1].valid) begin
            free_idx = SW'(i - 1);
            any_free = 1'b1;
         end
         if (slots[i-1].valid && slots[i-1].cnt == '0) begin
            elig_idx = SW'(i - 1);
            any_elig = 1'b1;
         end
      end
   end

   assign ack_o     = req_i && (cmd_i == CMD_WR || any_free);
   assign wr_accept = req_i && cmd_i == CMD_WR;
   assign rd_accept = req_i && cmd_i == CMD_RD && any_free;
   assign extra     = lfsr[2:0] & 3'(LAT_MASK);
   assign init_cnt  = CW'(LAT_MIN - 1) + CW'(extra);

   always_comb begin
      slots_nxt = slots;
      for (int unsigned i = 0; i < SLOTS; i++) begin
         if (slots[i].valid && slots[i].cnt != '0) begin
            slots_nxt[i].cnt = slots[i].cnt - 1'b1;
         end
      end
      if (any_elig) begin
         slots_nxt[elig_idx].valid = 1'b0;
      end
      if (rd_accept) begin
         slots_nxt[free_idx].valid = 1'b1;
         slots_nxt[free_idx].tid   = reqtid_i;
         slots_nxt[free_idx].cnt   = init_cnt;
         slots_nxt[free_idx].data  = mem[word];
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         slots     <= '{default: '0};
         resp_o    <= 1'b0;
         resptid_o <= '0;
         rdata_o   <= '0;
      end else begin
         slots  <= slots_nxt;
         resp_o <= any_elig;
         if (any_elig) begin
            resptid_o <= slots[elig_idx].tid;
            rdata_o   <= slots[elig_idx].data;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_accept) begin
         mem[word] <= wdata_i;
      end
   end

endmodule
